// File: rtl/ipv_frame_sched.sv
// Round-robin frame scheduler in front of a shared IPV reducer: grants one K-bit
// frame per slot, serializes it LSB-first and returns the id-tagged thermometer result.
module ipv_frame_sched #(
  parameter int K   = 4,
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*K-1:0] req_bits,
  output logic [N-1:0]   req_ready,
  output logic           ipv_o,
  input  logic [K-1:0]   vov_i,
  output logic           res_valid,
  output logic [IDW-1:0] res_id,
  output logic [K-1:0]   res_vov
);

  localparam logic [2:0]     PH_LAST = 3'(K - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(N - 1);
  localparam logic [IDW:0]   N_W     = (IDW + 1)'(N);
  localparam logic [N-1:0]   ONE_N   = {{(N - 1){1'b0}}, 1'b1};

  // First pending requester after 'last', wrapping at N; returns {found, id}.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] vld, input logic [IDW-1:0] last);
    logic [IDW:0] pick;
    logic [IDW:0] cand;
    pick = '0;
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, last} + (IDW + 1)'(i);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end else begin
        cand = cand;
      end
      if (!pick[IDW] && vld[cand[IDW-1:0]]) begin
        pick = {1'b1, cand[IDW-1:0]};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  logic [2:0]     phase_r;
  logic [IDW-1:0] last_r;
  logic [K-1:0]   sh_r;
  logic           frame_vld_r;
  logic [IDW-1:0] frame_id_r;
  logic [K:0]     tag_vld_r;
  logic [IDW-1:0] tag_id_r [K+1];

  logic [IDW:0]   pick_s;
  logic           slot_end_s;
  logic           hs_s;
  logic [IDW-1:0] win_id_s;
  logic [K-1:0]   win_bits_s;
  logic           tag_in_s;

  assign slot_end_s = (phase_r == PH_LAST);
  assign pick_s     = rr_pick(req_valid, last_r);
  assign win_id_s   = pick_s[IDW-1:0];
  assign hs_s       = slot_end_s & pick_s[IDW];
  assign tag_in_s   = (phase_r == 3'd0) & frame_vld_r;

  // Free-running slot phase, kept in lockstep with the reducer's own counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 3'd0;
    end else if (slot_end_s) begin
      phase_r <= 3'd0;
    end else begin
      phase_r <= phase_r + 3'd1;
    end
  end

  // One-hot grant, only offered in the last phase of a slot.
  always_comb begin
    if (hs_s) begin
      req_ready = ONE_N << win_id_s;
    end else begin
      req_ready = '0;
    end
  end

  // Frame data of the granted requester (req_ready is one-hot or zero).
  always_comb begin
    win_bits_s = '0;
    for (int i = 0; i < N; i++) begin
      win_bits_s = win_bits_s | (req_bits[i*K +: K] & {K{req_ready[i]}});
    end
  end

  // Frame load at the slot boundary, then LSB-first serialization; idle slots shift zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r        <= '0;
      ipv_o       <= 1'b0;
      frame_vld_r <= 1'b0;
      frame_id_r  <= '0;
      last_r      <= ID_LAST;
    end else if (slot_end_s) begin
      if (hs_s) begin
        sh_r        <= win_bits_s;
        ipv_o       <= win_bits_s[0];
        frame_vld_r <= 1'b1;
        frame_id_r  <= win_id_s;
        last_r      <= win_id_s;
      end else begin
        sh_r        <= '0;
        ipv_o       <= 1'b0;
        frame_vld_r <= 1'b0;
        frame_id_r  <= '0;
        last_r      <= last_r;
      end
    end else begin
      sh_r  <= sh_r >> 1;
      ipv_o <= sh_r[1];
    end
  end

  // Tag pipeline: entered in a frame's phase-0 cycle, leaves when the reducer result is on vov_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_r <= '0;
      for (int i = 0; i <= K; i++) begin
        tag_id_r[i] <= '0;
      end
    end else begin
      tag_vld_r   <= {tag_vld_r[K-1:0], tag_in_s};
      tag_id_r[0] <= tag_in_s ? frame_id_r : '0;
      for (int i = 1; i <= K; i++) begin
        tag_id_r[i] <= tag_id_r[i-1];
      end
    end
  end

  // Registered result strobe; id and vov are cleared outside valid results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_vov   <= '0;
    end else if (tag_vld_r[K]) begin
      res_valid <= 1'b1;
      res_id    <= tag_id_r[K];
      res_vov   <= vov_i;
    end else begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_vov   <= '0;
    end
  end

endmodule

// File: tb/tb_ipv_frame_sched.sv
// Bench for ipv_frame_sched: two instances (K=4,N=4 and K=2,N=2) with a behavioural
// reducer, a slot-level reference model compared every cycle, and literal anchors.
module tb_ipv_frame_sched;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0]  a_req_valid, a_req_ready, a_vov, a_res_vov;
  logic [15:0] a_req_bits;
  logic        a_ipv, a_res_valid;
  logic [1:0]  a_res_id;

  logic [1:0]  b_req_valid, b_req_ready, b_vov, b_res_vov;
  logic [3:0]  b_req_bits;
  logic        b_ipv, b_res_valid;
  logic [0:0]  b_res_id;

  int checks = 0;
  int failures = 0;
  int scyc = 0;

  ipv_frame_sched #(.K(4), .N(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_bits(a_req_bits),
    .req_ready(a_req_ready), .ipv_o(a_ipv), .vov_i(a_vov), .res_valid(a_res_valid),
    .res_id(a_res_id), .res_vov(a_res_vov));

  ipv_frame_sched #(.K(2), .N(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_bits(b_req_bits),
    .req_ready(b_req_ready), .ipv_o(b_ipv), .vov_i(b_vov), .res_valid(b_res_valid),
    .res_id(b_res_id), .res_vov(b_res_vov));

  always #5 clk = ~clk;

  function automatic int kof(int u);
    return (u == 0) ? 4 : 2;
  endfunction

  function automatic int nof(int u);
    return (u == 0) ? 4 : 2;
  endfunction

  // MSB-aligned thermometer of m ones in a k-bit field
  function automatic logic [3:0] therm(int k, int m);
    logic [3:0] t;
    t = '0;
    for (int i = 0; i < k; i++) begin
      if (i < m) t[k-1-i] = 1'b1;
    end
    return t;
  endfunction

  function automatic int popc(logic [3:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += (b[i] ? 1 : 0);
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, scyc, $time);
    end
  endtask

  // Behavioural reducer: counts ones over a slot, shows the thermometer two cycles after the slot.
  int         racc [2];
  int         rph [2];
  logic [3:0] rpend [2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        racc[u]  <= 0;
        rph[u]   <= 0;
        rpend[u] <= '0;
      end
      a_vov <= '0;
      b_vov <= '0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (rph[u] == kof(u) - 1) begin
          rpend[u] <= therm(kof(u), racc[u] + (((u == 0) ? a_ipv : b_ipv) ? 1 : 0));
          racc[u]  <= 0;
          rph[u]   <= 0;
        end else begin
          racc[u]  <= racc[u] + (((u == 0) ? a_ipv : b_ipv) ? 1 : 0);
          rph[u]   <= rph[u] + 1;
        end
      end
      if (rph[0] == 0) a_vov <= rpend[0];
      if (rph[1] == 0) b_vov <= rpend[1][1:0];
    end
  end

  // Reference model state: grant history per cycle, round-robin pointer, observation logs.
  int         m_cyc;
  int         m_last [2];
  logic       hv [2][16];
  int         hid [2][16];
  logic [3:0] hbits [2][16];
  int         glog_cyc [2][32];
  logic [3:0] glog_rdy [2][32];
  int         glog_n [2];
  int         rlog_cyc [2][32];
  int         rlog_id [2][32];
  logic [3:0] rlog_vov [2][32];
  int         rlog_n [2];
  logic       ipv_log [64];

  always @(negedge clk) begin : cmp
    int k, n, win, g, c, rid, exp_id;
    logic [3:0] vld, rdy, exp_rdy, ovov, exp_vov;
    logic ipv, rv, exp_ipv, exp_rv;
    if (!rst_n) begin
      m_cyc = 0;
      for (int u = 0; u < 2; u++) begin
        m_last[u] = nof(u) - 1;
        glog_n[u] = 0;
        rlog_n[u] = 0;
        for (int i = 0; i < 16; i++) hv[u][i] = 1'b0;
      end
      chk("reset_outs_a", {a_req_ready, a_ipv, a_res_valid, a_res_id, a_res_vov}, 32'd0);
      chk("reset_outs_b", {b_req_ready, b_ipv, b_res_valid, b_res_id, b_res_vov}, 32'd0);
    end else begin
      for (int u = 0; u < 2; u++) begin
        k = kof(u);
        n = nof(u);
        if (u == 0) begin
          vld = a_req_valid; rdy = a_req_ready; ipv = a_ipv; rv = a_res_valid;
          rid = int'(a_res_id); ovov = a_res_vov;
        end else begin
          vld = {2'b00, b_req_valid}; rdy = {2'b00, b_req_ready}; ipv = b_ipv; rv = b_res_valid;
          rid = int'(b_res_id); ovov = {2'b00, b_res_vov};
        end
        win = -1;
        if (m_cyc % k == k - 1) begin
          for (int j = 1; j <= n; j++) begin
            c = (m_last[u] + j) % n;
            if (win < 0 && vld[c]) win = c;
          end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        exp_ipv = 1'b0;
        for (int j = 0; j < k; j++) begin
          g = m_cyc - 1 - j;
          if (g >= 0 && hv[u][g % 16]) exp_ipv = hbits[u][g % 16][j];
        end
        exp_rv = 1'b0; exp_id = 0; exp_vov = '0;
        g = m_cyc - k - 3;
        if (g >= 0 && hv[u][g % 16]) begin
          exp_rv  = 1'b1;
          exp_id  = hid[u][g % 16];
          exp_vov = therm(k, popc(hbits[u][g % 16]));
        end
        chk($sformatf("req_ready_u%0d", u), rdy, exp_rdy);
        chk($sformatf("ipv_o_u%0d", u), ipv, exp_ipv);
        chk($sformatf("res_valid_u%0d", u), rv, exp_rv);
        if (exp_rv) begin
          chk($sformatf("res_id_u%0d", u), rid, exp_id);
          chk($sformatf("res_vov_u%0d", u), ovov, exp_vov);
        end
        if (rdy != 4'd0 && glog_n[u] < 32) begin
          glog_cyc[u][glog_n[u]] = m_cyc;
          glog_rdy[u][glog_n[u]] = rdy;
          glog_n[u] = glog_n[u] + 1;
        end
        if (rv && rlog_n[u] < 32) begin
          rlog_cyc[u][rlog_n[u]] = m_cyc;
          rlog_id[u][rlog_n[u]]  = rid;
          rlog_vov[u][rlog_n[u]] = ovov;
          rlog_n[u] = rlog_n[u] + 1;
        end
        hv[u][m_cyc % 16] = (win >= 0);
        if (win >= 0) begin
          hid[u][m_cyc % 16]   = win;
          hbits[u][m_cyc % 16] = (u == 0) ? a_req_bits[win*4 +: 4] : {2'b00, b_req_bits[win*2 +: 2]};
          m_last[u] = win;
        end
      end
      if (m_cyc < 64) ipv_log[m_cyc] = a_ipv;
      m_cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    scyc++;
  endtask

  task automatic goto_cyc(input int c);
    while (scyc < c) step();
  endtask

  // Reset for two edges; returns just after release, i.e. inside cycle 0.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    a_req_valid = '0;
    a_req_bits  = '0;
    b_req_valid = 2'b11;
    b_req_bits  = 4'b1101;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    scyc = 0;
  endtask

  initial begin : stim
    logic [3:0]  pat;
    logic [15:0] vv;
    rst_n = 1'b0;
    a_req_valid = '0; a_req_bits = '0; b_req_valid = '0; b_req_bits = '0;

    // single frame 1011 from requester 0; K=2 instance alternates 01/11 alongside
    do_reset();
    a_req_valid = 4'b0001;
    a_req_bits  = 16'h000B;
    goto_cyc(4);
    a_req_valid = 4'b0000;
    goto_cyc(16);
    chk("s1_grant_count", glog_n[0], 32'd1);
    chk("s1_grant_cycle", glog_cyc[0][0], 32'd3);
    chk("s1_grant_onehot", glog_rdy[0][0], 32'h1);
    pat = 4'b1011;
    for (int c = 4; c < 8; c++) chk($sformatf("s1_ipv_c%0d", c), ipv_log[c], pat[c-4]);
    chk("s1_res_count", rlog_n[0], 32'd1);
    chk("s1_res_cycle", rlog_cyc[0][0], 32'd10);
    chk("s1_res_id", rlog_id[0][0], 32'd0);
    chk("s1_res_vov", rlog_vov[0][0], 32'hE);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("k2_grant_cycle%0d", i), glog_cyc[1][i], 1 + 2 * i);
      chk($sformatf("k2_grant_onehot%0d", i), glog_rdy[1][i], (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    chk("k2_res0_cycle", rlog_cyc[1][0], 32'd6);
    chk("k2_res0_vov", rlog_vov[1][0], 32'h2);
    chk("k2_res1_cycle", rlog_cyc[1][1], 32'd8);
    chk("k2_res1_id", rlog_id[1][1], 32'd1);
    chk("k2_res1_vov", rlog_vov[1][1], 32'h3);

    // all four requesters continuously
    do_reset();
    a_req_valid = 4'hF;
    a_req_bits  = 16'hF731;
    goto_cyc(24);
    vv = 16'hFEC8;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("s2_grant_cycle%0d", i), glog_cyc[0][i], 3 + 4 * i);
      chk($sformatf("s2_grant_onehot%0d", i), glog_rdy[0][i], 32'd1 << (i % 4));
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s2_res_cycle%0d", i), rlog_cyc[0][i], 10 + 4 * i);
      chk($sformatf("s2_res_id%0d", i), rlog_id[0][i], i);
      chk($sformatf("s2_res_vov%0d", i), rlog_vov[0][i], vv[i*4 +: 4]);
    end

    // all-zero frame, idle slot, all-ones frame
    do_reset();
    a_req_valid = 4'b0001;
    a_req_bits  = 16'h0000;
    goto_cyc(4);
    a_req_valid = 4'b0000;
    goto_cyc(8);
    a_req_valid = 4'b0001;
    a_req_bits  = 16'h000F;
    goto_cyc(12);
    a_req_valid = 4'b0000;
    goto_cyc(24);
    chk("s3_res_count", rlog_n[0], 32'd2);
    chk("s3_res0_cycle", rlog_cyc[0][0], 32'd10);
    chk("s3_res0_vov", rlog_vov[0][0], 32'h0);
    chk("s3_res1_cycle", rlog_cyc[0][1], 32'd18);
    chk("s3_res1_vov", rlog_vov[0][1], 32'hF);

    // late request on 2, withdrawn pulse on 1
    do_reset();
    a_req_bits = 16'h5555;
    goto_cyc(4);
    a_req_valid = 4'b0010;
    goto_cyc(5);
    a_req_valid = 4'b0110;
    goto_cyc(6);
    a_req_valid = 4'b0100;
    goto_cyc(8);
    a_req_valid = 4'b0000;
    goto_cyc(16);
    chk("s4_grant_count", glog_n[0], 32'd1);
    chk("s4_grant_cycle", glog_cyc[0][0], 32'd7);
    chk("s4_grant_onehot", glog_rdy[0][0], 32'h4);
    chk("s4_res_id", rlog_id[0][0], 32'd2);
    chk("s4_res_vov", rlog_vov[0][0], 32'hC);

    // reset mid-frame with requests held through it
    do_reset();
    a_req_valid = 4'b0011;
    a_req_bits  = 16'h0077;
    goto_cyc(9);
    chk("s5_pre_grants", glog_n[0], 32'd2);
    chk("s5_pre_results", rlog_n[0], 32'd0);
    rst_n = 1'b0;
    #1;
    chk("s5_async_outs_a", {a_req_ready, a_ipv, a_res_valid, a_res_id, a_res_vov}, 32'd0);
    chk("s5_async_outs_b", {b_req_ready, b_ipv, b_res_valid, b_res_id, b_res_vov}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    scyc = 0;
    goto_cyc(16);
    chk("s5_post_grant_cycle", glog_cyc[0][0], 32'd3);
    chk("s5_post_grant_onehot", glog_rdy[0][0], 32'h1);
    chk("s5_post_res_cycle", rlog_cyc[0][0], 32'd10);
    chk("s5_post_res_id", rlog_id[0][0], 32'd0);
    chk("s5_post_res_vov", rlog_vov[0][0], 32'hE);

    // randomized traffic with occasional resets, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 749) do_reset();
      a_req_valid = 4'($urandom);
      a_req_bits  = 16'($urandom);
      b_req_valid = 2'($urandom);
      b_req_bits  = 4'($urandom);
      step();
    end
    a_req_valid = '0;
    b_req_valid = '0;
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ipv_frame_sched.md
# ipv_frame_sched

Round-robin scheduler that time-shares one `IPV_reducer` among N requesters. Each requester offers a K-bit IPV frame. The scheduler grants one frame per reducer frame slot and serializes its bits onto the reducer's `ipv_in`. It then captures the reducer's `vov` at the fixed result latency and returns the result tagged with the requester index. The block sits directly in front of the reducer, which shares its `clk` and `rst_n`.

## Interface
- `K`, 4: frame length in bits; equals the reducer's `k`; legal range 2..8.
- `N`, 4: number of requesters; legal range 2..8.
- `IDW`, derived as `$clog2(N)`: width of the requester index.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset; must be the same net as the reducer's reset.
- `req_valid` input N: requester i has a frame pending.
- `req_bits` input N*K: frame of requester i at `[i*K +: K]`; bit 0 is sent first.
- `req_ready` output N: one-hot grant; handshake completes when `req_valid[i] & req_ready[i]`.
- `ipv_o` output 1: drives the reducer's `ipv_in`.
- `vov_i` input K: the reducer's `vov`.
- `res_valid` output 1: one-cycle result strobe.
- `res_id` output IDW: requester index of the result.
- `res_vov` output K: captured thermometer result.

## Operation
- **Phase counter.** `phase` is a 3-bit counter, 0..K-1, wrapping at K-1. It resets to 0, runs every cycle with no stall, and mirrors the reducer's internal counter exactly.
- **Arbitration timing.** Arbitration happens only in cycles with `phase == K-1`.
  - The winner is the first requester with `req_valid` set, searching from `last+1` (mod N) upward.
  - `req_ready` is combinational on `req_valid` and `phase`. It is all-zero in every other phase and when no request is pending.
- **Round-robin pointer.** On a handshake, `last` is updated to the winner. `last` resets to N-1, so requester 0 has first priority.
- **Frame load.** On a handshake, `req_bits[winner]` loads into the K-bit shift register `sh`, `frame_vld` is set to 1, and `frame_id` is set to the winner. With no handshake, `sh` is 0 and `frame_vld` is 0, making an idle frame.
- **Serialization.** During phase p of the following frame, `ipv_o = sh[p]`. This is implemented as a registered output that shifts LSB-first, so `ipv_o` is glitch-free and 0 during idle frames.
- **Result tracking.** A tag pipeline of depth K+2 carries (`frame_vld`, `frame_id`) from the frame's phase-0 cycle.
  - When the tag emerges, `res_valid` is set to the tag's valid bit, `res_id` to the tag's id, and `res_vov` to `vov_i`. All three are registered.
  - Idle frames never produce `res_valid`.
  - An all-zero frame does produce `res_valid = 1` with `res_vov = 0`.
- **Result encoding.**
  - `res_vov` is MSB-aligned thermometer: a frame with m ones gives the top m bits set.
  - For a validly tagged result, `res_vov` must equal the thermometer of `popcount(req_bits)`. Synthesis is not required to check this; it is an assertion only.
- **No backpressure on results.** The consumer must accept every `res_valid`.
- **Withdrawn requests.** A requester whose `req_valid` drops before `phase == K-1` is not granted. Holding `req_bits` stable is required only in the handshake cycle.

## Timing
- **Cycle numbering.** Cycle 0 is the first rising edge after `rst_n` deasserts, and `phase = cycle mod K`.
- **Grant-to-data.** Grant in cycle g (phase K-1) leads to frame bits on `ipv_o` in cycles g+1 .. g+K.
- **Result latency.** A frame starting in cycle s (phase 0) has its result visible on `vov_i` in cycle s+K+1. The scheduler registers it, so `res_valid` is high in cycle s+K+2, i.e. K+3 cycles after the grant.
- **Throughput.** One frame per K cycles. With K≥2, at most two tags are in flight, so frames and results overlap back-to-back with no gap.
- **Reset values.** `req_ready` = 0, `ipv_o` = 0, `res_valid` = 0, `res_id` = 0, `res_vov` = 0. Internally `phase` = 0, `last` = N-1, and `sh`, `frame_vld` and the tag pipeline are all 0.
- **Reset mid-operation.** All outputs go to their reset values asynchronously. In-flight frames and results are discarded and never reported. After release, both blocks restart at phase 0 in lockstep.
- **Simultaneous requests.** Exactly one grant per slot; the others hold `req_valid` and wait.
- **Wrap-around.** After requester N-1 is granted, the search starts at requester 0.

## Test plan
- **Single frame (K=4, N=4).** Reset, then `req_valid[0]` with bits 4'b1011 held from cycle 0.
  - `req_ready[0]` = 1 in cycle 3.
  - `ipv_o` = 1,1,0,1 in cycles 4..7.
  - `res_valid` in cycle 10 with `res_id` 0 and `res_vov` 4'b1110.
  - `res_valid` is low in every other cycle.
- **All four requesters, continuous.** Bits: req0 4'b0001, req1 4'b0011, req2 4'b0111, req3 4'b1111.
  - Grants go to 0,1,2,3,0 in cycles 3,7,11,15,19.
  - Results arrive in cycles 10,14,18,22 with vov 1000, 1100, 1110, 1111.
- **Boundary values.** Frame 4'b0000 gives `res_valid` = 1 with `res_vov` 4'b0000. Frame 4'b1111 gives 4'b1111. An idle slot between them produces no strobe.
- **Late and withdrawn requests.**
  - `req_valid[2]` raised in cycle 5 (phase 1) is granted in cycle 7, not earlier.
  - `req_valid[1]` pulsed only in cycles 4..5 is never granted.
- **Reset mid-frame.** Reset pulses low in cycle 9 while a frame is in flight.
  - All outputs are 0 at once, and no stale `res_valid` appears afterwards.
  - A request held through reset is granted in cycle 3 after release, with requester 0 first.
- **K=2, N=2.** Alternating requests 2'b01 and 2'b11.
  - Grants occur every 2 cycles.
  - Each result appears K+3 = 5 cycles after its grant, with vov 10 and 11.
